// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension decode stage:
// extension mode encodings and default field widths.
package imm_pkg;

    localparam int IMM_MODE_W = 2;

    localparam logic [IMM_MODE_W-1:0] MODE_SEXT     = 2'b00;
    localparam logic [IMM_MODE_W-1:0] MODE_ZEXT     = 2'b01;
    localparam logic [IMM_MODE_W-1:0] MODE_SEXT_SHL = 2'b10;
    localparam logic [IMM_MODE_W-1:0] MODE_UPPER    = 2'b11;

    localparam int DEF_N_IN  = 17;
    localparam int DEF_N_OUT = 32;
    localparam int DEF_SHIFT = 2;

endpackage

// File: rtl/extend_core.sv
// Combinational immediate widener: sign, zero, sign-then-shift (branch
// offsets) and upper (lui-style) placement of an N_IN-bit field.
module extend_core
    import imm_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic [N_IN-1:0]       imm,
    input  logic [IMM_MODE_W-1:0] mode,
    output logic [N_OUT-1:0]      result
);

    logic [N_OUT-1:0] sext;
    logic [N_OUT-1:0] zext;
    logic [N_OUT-1:0] upper;

    assign sext[N_IN-1:0] = imm;
    assign zext[N_IN-1:0] = imm;

    for (genvar i = N_IN; i < N_OUT; i++) begin : g_upper
        assign sext[i] = imm[N_IN-1];
        assign zext[i] = 1'b0;
    end

    assign upper = {imm, {(N_OUT-N_IN){1'b0}}};

    always_comb begin
        result = sext;
        case (mode)
            MODE_SEXT:     result = sext;
            MODE_ZEXT:     result = zext;
            MODE_SEXT_SHL: result = sext << SHIFT;
            MODE_UPPER:    result = upper;
            default:       result = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage with valid/ready on both sides.
// A main register feeds the output; a skid register absorbs one extra item.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT-1:0]      out_data
);

    if (N_IN < 1 || N_IN >= N_OUT || SHIFT < 0 || SHIFT >= N_OUT) begin : g_bad_params
        $error("imm_extend_pipe: need 1 <= N_IN < N_OUT and 0 <= SHIFT < N_OUT");
    end

    logic [N_OUT-1:0] ext;
    logic [N_OUT-1:0] main_data;
    logic [N_OUT-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             drain;

    extend_core #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .SHIFT (SHIFT)
    ) u_core (
        .imm    (in_imm),
        .mode   (in_mode),
        .result (ext)
    );

    // Ready depends only on the skid flop, so out_ready never reaches in_ready.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                // in_ready is low whenever skid is occupied, so no input arrives here
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= ext;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= ext;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: directed cases plus random traffic against a
// queue-based reference that extends immediates with integer arithmetic.
module tb_imm_extend_pipe;

    localparam int N_IN  = 17;
    localparam int N_OUT = 32;
    localparam int SHIFT = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N_IN-1:0]  in_imm = '0;
    logic [1:0]       in_mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N_OUT-1:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;

    logic [63:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic        ctl_prev   = 1'b1;
    logic [N_OUT-1:0] data_prev = '0;

    imm_extend_pipe #(.N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Interpret the field as a number, then scale and wrap modulo 2^N_OUT.
    function automatic logic [63:0] ref_ext(input logic [N_IN-1:0] imm, input logic [1:0] mode);
        longint v = longint'(imm);
        longint m = longint'(1) << N_OUT;
        if ((mode == 2'b00 || mode == 2'b10) && v >= (longint'(1) << (N_IN-1)))
            v = v - (longint'(1) << N_IN);
        if (mode == 2'b10) v = v * (longint'(1) << SHIFT);
        if (mode == 2'b11) v = v * (longint'(1) << (N_OUT-N_IN));
        v = v % m;
        if (v < 0) v = v + m;
        return 64'(v);
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clock) begin
        logic [63:0] e;
        if (out_valid && stall_prev && !ctl_prev)
            chk("stall_stable", 64'(out_data), 64'(data_prev));
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_0000_0000;
                chk("fifo_order", 64'(out_data), e);
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(ref_ext(in_imm, in_mode));
        end
        stall_prev = out_valid && !out_ready;
        data_prev  = out_data;
        ctl_prev   = reset || flush;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [N_IN-1:0] imm, input logic [1:0] mode);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
    endtask

    initial begin
        int start;
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_data",  64'(out_data),  64'd0);

        // Each mode, one-cycle latency
        out_ready = 1'b1;
        offer(17'h10000, 2'b00); step(); chk("sext",      64'(out_data), 64'hFFFF0000);
        offer(17'h10000, 2'b01); step(); chk("zext",      64'(out_data), 64'h00010000);
        offer(17'h1FFFF, 2'b10); step(); chk("shl_neg",   64'(out_data), 64'hFFFFFFFC);
        offer(17'h00001, 2'b11); step(); chk("upper",     64'(out_data), 64'h00008000);
        offer(17'h0FFFF, 2'b10); step(); chk("shl_pos",   64'(out_data), 64'h0003FFFC);
        chk("lat_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        chk("idle_valid", 64'(out_valid), 64'd0);

        // Backpressure: A to main, B to skid, C held off
        out_ready = 1'b0;
        offer(17'd1, 2'b01); step();
        chk("bp_ready_a", 64'(in_ready), 64'd1);
        offer(17'd2, 2'b01); step();
        chk("bp_ready_b", 64'(in_ready), 64'd0);
        offer(17'd3, 2'b01); step();
        chk("bp_hold_a",  64'(out_data), 64'd1);
        step();
        chk("bp_hold_a2", 64'(out_data), 64'd1);
        chk("bp_ready_c", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step(); chk("bp_out_b", 64'(out_data), 64'd2);
        chk("bp_ready_rise", 64'(in_ready), 64'd1);
        step(); chk("bp_out_c", 64'(out_data), 64'd3);
        in_valid = 1'b0;
        step(); chk("bp_empty", 64'(out_valid), 64'd0);

        // Streaming at full rate
        start = n_out;
        for (int i = 0; i < 8; i++) begin
            chk("stream_ready", 64'(in_ready), 64'd1);
            offer(N_IN'($urandom), 2'($urandom));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stream_count", 64'(n_out - start), 64'd8);

        // Flush with both registers occupied
        out_ready = 1'b0;
        offer(17'h00011, 2'b00); step();
        offer(17'h00022, 2'b00); step();
        offer(17'h00033, 2'b00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        offer(17'h00005, 2'b00); step();
        chk("post_flush", 64'(out_data), 64'h00000005);
        in_valid = 1'b0;
        step();

        // Reset during a stall, coinciding with an accepted input
        out_ready = 1'b0;
        offer(17'h00044, 2'b01); step();
        offer(17'h00055, 2'b01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(in_ready),  64'd1);
        chk("mrst_data",  64'(out_data),  64'd0);
        out_ready = 1'b1;
        step(); step();
        chk("mrst_no_ghost", 64'(out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_imm    = N_IN'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (out_valid || exp_q.size() > 0); i++) step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
